dff_pipe: RTL and testbench
===========================

# dff_pipe

Parametrised multi-stage D flip-flop pipeline. It is the successor to the single-bit D flop: configurable data width and stage count, with per-stage valid tracking, a clock-enable stall, a synchronous clear and an occupancy counter. It sits between producer and consumer logic wherever a fixed-latency, stallable delay line with true and complement outputs is needed.

## Interface
- WIDTH, 8, data bits per stage; must be ≥1
- DEPTH, 3, number of register stages (latency in enabled cycles); must be ≥1
- RESET_VAL, '0, WIDTH-bit value loaded into every stage on reset, clear, or invalid input
- clk  input  1  single clock; all state updates on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  advance pipeline when high; hold all state when low
- clr  input  1  synchronous clear of all stages
- d  input  WIDTH  input data
- d_valid  input  1  qualifies d
- q  output  WIDTH  data of last stage
- qb  output  WIDTH  bitwise complement of q
- q_valid  output  1  valid flag of last stage
- occ  output  $clog2(DEPTH+1)  number of valid stages currently held

## Operation
- Stages 0..DEPTH-1; stage 0 is fed from d, stage DEPTH-1 drives q and q_valid.
- Priority per clock edge is clr > en > hold.
  - clr=1: every stage data = RESET_VAL, every valid = 0, occ = 0. This applies regardless of en.
  - clr=0, en=1: stage i takes stage i-1 (data and valid). Stage 0 takes d and valid=1 when d_valid=1; it takes RESET_VAL and valid=0 when d_valid=0. Undriven or X data on an invalid input never enters the pipe.
  - clr=0, en=0: all stages, valids and occ hold.
- occ update on an enabled edge: occ_next = occ − valid[DEPTH-1] + d_valid. The width is sized so it never overflows (max DEPTH) or underflows (min 0).
- qb = ~q at all times, purely combinational from the stage register. There is no separate qb flop.
- occ is a registered counter. It must always equal the popcount of the stage valids; the bench checks this invariant every cycle.

## Timing
- Reset (reset_n=0): asynchronous, takes effect immediately without a clock edge.
  - All stages = RESET_VAL, all valids = 0.
  - q = RESET_VAL, qb = ~RESET_VAL, q_valid = 0, occ = 0.
- Reset release: the first rising edge with reset_n=1 is an ordinary cycle.
- Reset asserted mid-operation discards all contents. No partial state survives.
- Latency: a sample accepted at edge k appears on q/q_valid after edge k+DEPTH−1 when en is high on every intervening edge. That is, it is visible DEPTH edges after launch, counting the capture edge.
- Each low-en cycle adds exactly one cycle of latency to every in-flight sample.
- Simultaneous clr and en: clr wins and the incoming d is dropped.
- Simultaneous d_valid=1 and valid[DEPTH-1]=1 with en=1: occ is unchanged.

## Configuration
- Macro DFF_PIPE_TAPS_EN.
- Defined: the block adds output port taps of width DEPTH*WIDTH (stage i at bits [i*WIDTH +: WIDTH]) and tap_valid of width DEPTH. Both are driven directly from the stage registers and follow the same reset values.
- Undefined: neither port exists and there is no logic for them. Core behaviour is identical in both builds.

## Structure
- Shared package dff_pkg holds:
  - the default width/depth localparams;
  - a typedef for the packed stage record (data plus valid);
  - a function computing the occ width.
- One sub-module, dff_stage: a single WIDTH-bit register plus valid bit, with async active-low reset, enable, synchronous clear and load value. dff_pipe instantiates it DEPTH times in a generate loop and owns the occ counter and qb.

## Test plan
- Reset: hold reset_n=0 with d=X and d_valid=X for 3 edges → q=8'h00, qb=8'hFF, q_valid=0, occ=0, with no X on any output.
- Latency: reset released; en=1; d=8'hA5 with d_valid=1 for one edge, then d_valid=0 → q=8'hA5, qb=8'h5A, q_valid=1 exactly 3 edges later for one cycle; occ goes 1,1,1,0.
- Stall: stream 8'h01, 8'h02, 8'h03 back-to-back, drop en for 2 cycles after the second edge → outputs and occ freeze at 2 during the stall; 8'h01 emerges 2 cycles late; order is preserved.
- Full pipe: d_valid=1 continuously with d=8'h10, 8'h11, … → occ saturates at 3 and stays 3 while input and output valids overlap.
- Clear vs enable: fill with 3 valids, assert clr=1 and en=1 with d_valid=1 and d=8'hEE → next cycle occ=0, q_valid=0, q=8'h00, and 8'hEE never appears.
- Async reset mid-stream: pulse reset_n low between edges while occ=2 → outputs reach reset values before the next edge; the pipeline restarts empty.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe delay line: default geometry,
// the packed stage record and the occupancy-counter width helper.
package dff_pkg;

    localparam int DFF_WIDTH_DEF = 8;
    localparam int DFF_DEPTH_DEF = 3;

    // One pipeline stage at the default width: data plus its valid flag.
    typedef struct packed {
        logic                     valid;
        logic [DFF_WIDTH_DEF-1:0] data;
    } dff_rec_t;

    // Width needed to count 0..depth valid stages without wrapping.
    function automatic int dff_occ_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_stage.sv
// Single pipeline stage: WIDTH-bit data register plus valid bit.
// Asynchronous active-low reset, synchronous clear, clock enable.
module dff_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    // Stage register: reset/clear load RESET_VAL and drop valid; en advances; else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg  <= RESET_VAL;
            valid_reg <= 1'b0;
        end else if (clr) begin
            data_reg  <= RESET_VAL;
            valid_reg <= 1'b0;
        end else if (en) begin
            data_reg  <= d;
            valid_reg <= d_valid;
        end
    end

    assign q       = data_reg;
    assign q_valid = valid_reg;

endmodule

// File: rtl/dff_pipe.sv
// Parametrised stallable D flip-flop pipeline with per-stage valid,
// synchronous clear, occupancy counter and true/complement outputs.
// Optional build macro DFF_PIPE_TAPS_EN exposes every stage on taps/tap_valid.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH_DEF,
    parameter int               DEPTH     = DFF_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             en,
    input  logic                             clr,
    input  logic [WIDTH-1:0]                 d,
    input  logic                             d_valid,
    output logic [WIDTH-1:0]                 q,
    output logic [WIDTH-1:0]                 qb,
    output logic                             q_valid,
    output logic [dff_occ_width(DEPTH)-1:0]  occ
`ifdef DFF_PIPE_TAPS_EN
    ,
    output logic [DEPTH*WIDTH-1:0]           taps,
    output logic [DEPTH-1:0]                 tap_valid
`endif
);

    localparam int OCC_W = dff_occ_width(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t           stage_in  [DEPTH];
    stage_t           stage_out [DEPTH];
    logic [DEPTH-1:0] stage_valid;

    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                // Invalid input is replaced by RESET_VAL so X data never enters the pipe.
                assign stage_in[gi].data  = d_valid ? d : RESET_VAL;
                assign stage_in[gi].valid = d_valid;
            end else begin : g_body
                assign stage_in[gi] = stage_out[gi-1];
            end

            dff_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (en),
                .clr     (clr),
                .d       (stage_in[gi].data),
                .d_valid (stage_in[gi].valid),
                .q       (stage_out[gi].data),
                .q_valid (stage_out[gi].valid)
            );

            assign stage_valid[gi] = stage_out[gi].valid;

`ifdef DFF_PIPE_TAPS_EN
            assign taps[gi*WIDTH +: WIDTH] = stage_out[gi].data;
            assign tap_valid[gi]           = stage_out[gi].valid;
`endif
        end
    endgenerate

    // Occupancy next-state: clear empties, an enabled edge adds entering and removes leaving samples.
    always_comb begin
        occ_next = occ_reg;
        if (clr) begin
            occ_next = '0;
        end else if (en) begin
            occ_next = occ_reg + OCC_W'(d_valid) - OCC_W'(stage_valid[DEPTH-1]);
        end
    end

    // Occupancy register, tracks the popcount of stage valids.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

    assign q       = stage_out[DEPTH-1].data;
    assign qb      = ~stage_out[DEPTH-1].data;
    assign q_valid = stage_out[DEPTH-1].valid;
    assign occ     = occ_reg;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe (WIDTH=8, DEPTH=3, RESET_VAL=0).
module tb_dff_pipe;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       d_valid;
    logic [7:0] q;
    logic [7:0] qb;
    logic       q_valid;
    logic [1:0] occ;

    int n_vec = 0;
    int n_bad = 0;
    bit inv_on = 0;

    dff_pipe #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_valid (d_valid),
        .q       (q),
        .qb      (qb),
        .q_valid (q_valid),
        .occ     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // occ must equal popcount of stage valids at every sample point.
    always @(negedge clk) begin
        if (inv_on) begin
            n_vec++;
            if (occ !== 2'($countones(dut.stage_valid))) begin
                n_bad++;
                $display("FAIL occ_invariant t=%0t occ=%0d popcount=%0d", $time, occ,
                         $countones(dut.stage_valid));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b1;
        clr     = 1'b0;
        d       = 8'hxx;
        d_valid = 1'bx;
        for (int i = 0; i < 3; i++) cycle();
        n_vec++;
        if (q !== 8'h00 || qb !== 8'hFF || q_valid !== 1'b0 || occ !== 2'd0) begin
            n_bad++;
            $display("FAIL reset q=%h qb=%h qv=%b occ=%0d expected q=00 qb=FF qv=0 occ=0",
                     q, qb, q_valid, occ);
        end
        d       = 8'h00;
        d_valid = 1'b0;
        reset_n = 1'b1;
        inv_on  = 1'b1;
        $display("reset: q=%h qb=%h qv=%b occ=%0d", q, qb, q_valid, occ);
    endtask

    task automatic test_latency();
        logic [7:0] exp_q   [4] = '{8'h00, 8'h00, 8'hA5, 8'h00};
        logic       exp_v   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] exp_occ [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        en = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d       = (i == 0) ? 8'hA5 : 8'h00;
            d_valid = (i == 0);
            cycle();
            n_vec++;
            if (q !== exp_q[i] || qb !== ~exp_q[i] || q_valid !== exp_v[i] || occ !== exp_occ[i]) begin
                n_bad++;
                $display("FAIL latency edge%0d q=%h qb=%h qv=%b occ=%0d expected q=%h qv=%b occ=%0d",
                         i + 1, q, qb, q_valid, occ, exp_q[i], exp_v[i], exp_occ[i]);
            end
            $display("latency edge%0d: q=%h qv=%b occ=%0d", i + 1, q, q_valid, occ);
        end
    endtask

    task automatic test_stall();
        logic       t_en    [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       t_dv    [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] t_d     [8] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_q   [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        logic       exp_v   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] exp_occ [8] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en      = t_en[i];
            d_valid = t_dv[i];
            d       = t_d[i];
            cycle();
            n_vec++;
            if (q !== exp_q[i] || qb !== ~exp_q[i] || q_valid !== exp_v[i] || occ !== exp_occ[i]) begin
                n_bad++;
                $display("FAIL stall edge%0d q=%h qb=%h qv=%b occ=%0d expected q=%h qv=%b occ=%0d",
                         i + 1, q, qb, q_valid, occ, exp_q[i], exp_v[i], exp_occ[i]);
            end
            $display("stall edge%0d en=%b: q=%h qv=%b occ=%0d", i + 1, en, q, q_valid, occ);
        end
    endtask

    task automatic test_full();
        logic [7:0] exp_q   [6] = '{8'h00, 8'h00, 8'h10, 8'h11, 8'h12, 8'h13};
        logic       exp_v   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] exp_occ [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        en  = 1'b1;
        clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d       = 8'h10 + 8'(i);
            d_valid = 1'b1;
            cycle();
            n_vec++;
            if (q !== exp_q[i] || qb !== ~exp_q[i] || q_valid !== exp_v[i] || occ !== exp_occ[i]) begin
                n_bad++;
                $display("FAIL full edge%0d q=%h qb=%h qv=%b occ=%0d expected q=%h qv=%b occ=%0d",
                         i + 1, q, qb, q_valid, occ, exp_q[i], exp_v[i], exp_occ[i]);
            end
            $display("full edge%0d: q=%h qv=%b occ=%0d", i + 1, q, q_valid, occ);
        end
    endtask

    // Runs on the full pipe left by test_full.
    task automatic test_clear_vs_en();
        en      = 1'b1;
        clr     = 1'b1;
        d       = 8'hEE;
        d_valid = 1'b1;
        cycle();
        n_vec++;
        if (q !== 8'h00 || qb !== 8'hFF || q_valid !== 1'b0 || occ !== 2'd0) begin
            n_bad++;
            $display("FAIL clear q=%h qb=%h qv=%b occ=%0d expected q=00 qb=FF qv=0 occ=0",
                     q, qb, q_valid, occ);
        end
        $display("clear: q=%h qv=%b occ=%0d", q, q_valid, occ);
        clr     = 1'b0;
        d       = 8'h00;
        d_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (q !== 8'h00 || q_valid !== 1'b0 || occ !== 2'd0) begin
                n_bad++;
                $display("FAIL clear_drain edge%0d q=%h qv=%b occ=%0d expected q=00 qv=0 occ=0",
                         i + 1, q, q_valid, occ);
            end
            $display("clear drain edge%0d: q=%h qv=%b occ=%0d", i + 1, q, q_valid, occ);
        end
    endtask

    task automatic test_async_reset();
        en  = 1'b1;
        clr = 1'b0;
        d_valid = 1'b1;
        d = 8'h21;
        cycle();
        d = 8'h22;
        cycle();
        n_vec++;
        if (occ !== 2'd2) begin
            n_bad++;
            $display("FAIL async_pre occ=%0d expected 2", occ);
        end
        // Pulse reset between edges; outputs must clear without a clock edge.
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (q !== 8'h00 || qb !== 8'hFF || q_valid !== 1'b0 || occ !== 2'd0) begin
            n_bad++;
            $display("FAIL async_reset q=%h qb=%h qv=%b occ=%0d expected q=00 qb=FF qv=0 occ=0",
                     q, qb, q_valid, occ);
        end
        $display("async reset: q=%h qv=%b occ=%0d", q, q_valid, occ);
        #1;
        reset_n = 1'b1;
        d_valid = 1'b0;
        d       = 8'h00;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++;
            if (q !== 8'h00 || q_valid !== 1'b0 || occ !== 2'd0) begin
                n_bad++;
                $display("FAIL async_restart edge%0d q=%h qv=%b occ=%0d expected q=00 qv=0 occ=0",
                         i + 1, q, q_valid, occ);
            end
            $display("restart edge%0d: q=%h qv=%b occ=%0d", i + 1, q, q_valid, occ);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        clr     = 1'b0;
        d       = 8'h00;
        d_valid = 1'b0;
        test_reset();
        test_latency();
        test_stall();
        test_full();
        test_clear_vs_en();
        test_async_reset();
        inv_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
